// File: rtl/store_merge_unit.sv
// Store unit: SW writes the word directly; SH/SB read the aligned word, merge lanes, write back.
// Optional misalignment detection is enabled by defining ALIGN_CHECK_EN.
module store_merge_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] reg_data,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] TypeSw  = 2'b00;
  localparam logic [1:0] TypeSh  = 2'b01;
  localparam logic [1:0] TypeSb  = 2'b10;
  localparam logic [2:0] LastCnt = 3'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StWrite,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  type_q, type_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rd_q, rd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] merged;

`ifdef ALIGN_CHECK_EN
  logic err_q, err_d;
  logic misaligned;

  // SB is always aligned; SH needs halfword, SW word alignment.
  always_comb begin
    misaligned = 1'b0;
    if (store_type == TypeSw) misaligned = (addr[1:0] != 2'b00);
    if (store_type == TypeSh) misaligned = addr[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      type_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    type_d  = type_q;
    data_d  = data_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
`ifdef ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d = addr;
          type_d = store_type;
          data_d = reg_data;
`ifdef ALIGN_CHECK_EN
          err_d  = misaligned;
`endif
          case (store_type)
            TypeSw:  state_d = StWrite;
            TypeSh:  state_d = StRead;
            TypeSb:  state_d = StRead;
            default: state_d = StDone;
          endcase
`ifdef ALIGN_CHECK_EN
          if (misaligned) state_d = StDone;
`endif
        end
      end
      StRead: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == LastCnt) begin
          rd_d    = mem_rdata;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Little-endian lane merge of the register data into the read word.
  always_comb begin
    merged = rd_q;
    case (type_q)
      TypeSw: merged = data_q;
      TypeSh: begin
        if (addr_q[1]) merged[31:16] = data_q[15:0];
        else           merged[15:0]  = data_q[15:0];
      end
      TypeSb: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = data_q[7:0];
          2'd1:    merged[15:8]  = data_q[7:0];
          2'd2:    merged[23:16] = data_q[7:0];
          default: merged[31:24] = data_q[7:0];
        endcase
      end
      default: merged = rd_q;
    endcase
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wr    = (state_q == StWrite);
  assign mem_wdata = mem_wr ? merged : 32'h0;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
`ifdef ALIGN_CHECK_EN
  assign err       = done & err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: vector table plus multi-cycle corner sequences.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] reg_data;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  // One-cycle read latency memory model.
  always @(posedge clk) mem_rdata <= mem[mem_addr[7:2]];

  store_merge_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .store_type (store_type),
    .addr       (addr),
    .reg_data   (reg_data),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic [31:0] a;
    logic [31:0] rv;
    logic [31:0] init;
    int          exp_wr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_waddr;
    int          exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and observe until done (bounded).
  task automatic do_op(input logic [1:0] st, input logic [31:0] a, input logic [31:0] rv,
                       output int wr_cnt, output logic [31:0] wdata, output logic [31:0] waddr,
                       output int done_cyc, output logic err_seen);
    wr_cnt = 0; wdata = 'x; waddr = 'x; done_cyc = -1; err_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; store_type = st; addr = a; reg_data = rv;
    @(posedge clk);
    #1 start = 1'b0; store_type = 2'b11; addr = 32'hFFFF_FFFF; reg_data = 32'h0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem_wr) begin
        wr_cnt++;
        wdata = mem_wdata;
        waddr = mem_addr;
      end
      if (done) begin
        done_cyc = c;
        err_seen = err;
        break;
      end
    end
  endtask

  initial begin
    int          wr_cnt, done_cyc, dcount;
    logic [31:0] wdata, waddr;
    logic        err_seen;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    reset = 1'b1; start = 1'b0; store_type = 2'b11; addr = '0; reg_data = '0;

    vecs[0] = '{"sw_10",  2'b00, 32'h10, 32'hDEADBEEF, 32'h0,        1, 32'hDEADBEEF, 32'h10, 2, 1'b0};
    vecs[1] = '{"sb_13",  2'b10, 32'h13, 32'h000000AA, 32'h11223344, 1, 32'hAA223344, 32'h10, 4, 1'b0};
    vecs[2] = '{"sh_12",  2'b01, 32'h12, 32'h0000BEEF, 32'h11223344, 1, 32'hBEEF3344, 32'h10, 4, 1'b0};
    vecs[3] = '{"sh_10",  2'b01, 32'h10, 32'h0000BEEF, 32'h11223344, 1, 32'h1122BEEF, 32'h10, 4, 1'b0};
    vecs[4] = '{"sb_20",  2'b10, 32'h20, 32'hFFFFFF55, 32'h11223344, 1, 32'h11223355, 32'h20, 4, 1'b0};
    vecs[5] = '{"sb_25",  2'b10, 32'h25, 32'h00000055, 32'hA0B0C0D0, 1, 32'hA0B055D0, 32'h24, 4, 1'b0};
    vecs[6] = '{"sb_2a",  2'b10, 32'h2A, 32'h12345677, 32'hA0B0C0D0, 1, 32'hA077C0D0, 32'h28, 4, 1'b0};
    vecs[7] = '{"nop",    2'b11, 32'h30, 32'h12345678, 32'h0,        0, 32'h0,        32'h0,  1, 1'b0};
`ifdef ALIGN_CHECK_EN
    vecs[8] = '{"sw_11",  2'b00, 32'h11, 32'hCAFEF00D, 32'h0,        0, 32'h0,        32'h0,  1, 1'b1};
    vecs[9] = '{"sh_33",  2'b01, 32'h33, 32'h0000BEEF, 32'h11223344, 0, 32'h0,        32'h0,  1, 1'b1};
`else
    vecs[8] = '{"sw_11",  2'b00, 32'h11, 32'hCAFEF00D, 32'h0,        1, 32'hCAFEF00D, 32'h10, 2, 1'b0};
    vecs[9] = '{"sh_33",  2'b01, 32'h33, 32'h0000BEEF, 32'h11223344, 1, 32'hBEEF3344, 32'h30, 4, 1'b0};
`endif

    // Reset state
    #1;
    check("reset_outputs", {31'h0, busy, done, mem_wr, err}, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'h0);

    foreach (vecs[i]) begin
      mem[vecs[i].a[7:2]] = vecs[i].init;
      do_op(vecs[i].st, vecs[i].a, vecs[i].rv, wr_cnt, wdata, waddr, done_cyc, err_seen);
      check({vecs[i].name, "_done_cyc"}, done_cyc, vecs[i].exp_done);
      check({vecs[i].name, "_writes"}, wr_cnt, vecs[i].exp_wr);
      check({vecs[i].name, "_err"}, {31'h0, err_seen}, {31'h0, vecs[i].exp_err});
      if (vecs[i].exp_wr != 0) begin
        check({vecs[i].name, "_wdata"}, wdata, vecs[i].exp_wdata);
        check({vecs[i].name, "_waddr"}, waddr, vecs[i].exp_waddr);
      end
      @(negedge clk);
      check({vecs[i].name, "_idle_after"}, {30'h0, busy, done}, 32'h0);
    end

    // start held high with changing inputs during an SB: only the first request runs.
    mem[4] = 32'h11223344;
    wr_cnt = 0; dcount = 0; wdata = 'x;
    @(negedge clk);
    start = 1'b1; store_type = 2'b10; addr = 32'h13; reg_data = 32'h000000AA;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      store_type = 2'b00; addr = 32'h40; reg_data = 32'hFFFFFFFF;
      if (mem_wr) begin wr_cnt++; wdata = mem_wdata; end
      if (done) begin dcount++; start = 1'b0; break; end
    end
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
      if (done) dcount++;
    end
    check("hold_start_writes", wr_cnt, 1);
    check("hold_start_dones", dcount, 1);
    check("hold_start_wdata", wdata, 32'hAA223344);

    // Reset during WAIT of an SH aborts without a write.
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1; store_type = 2'b01; addr = 32'h12; reg_data = 32'h0000BEEF;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    if (mem_wr) wr_cnt++;
    @(negedge clk);
    if (mem_wr) wr_cnt++;
    check("pre_reset_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("abort_outputs", {31'h0, busy, done, mem_wr, err}, 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_wr) wr_cnt++;
    end
    check("abort_no_write", wr_cnt, 0);
    do_op(2'b00, 32'h10, 32'hDEADBEEF, wr_cnt, wdata, waddr, done_cyc, err_seen);
    check("post_reset_sw_done", done_cyc, 2);
    check("post_reset_sw_writes", wr_cnt, 1);
    check("post_reset_sw_wdata", wdata, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
